// File: rtl/sail_mem_arb_pkg.sv
// Shared types for the Sail emulator memory arbiter: FSM states, requester
// ids, the latched request record and the byte-count clamp helper.
package sail_mem_arb_pkg;

  localparam int unsigned MAX_BYTES_DEF = 8;
  localparam int unsigned ADDR_W_DEF    = 64;
  localparam int unsigned NB_W_DEF      = $clog2(MAX_BYTES_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_D = 1'b0,
    REQ_I = 1'b1
  } req_id_e;

  // Request captured at acceptance; sized by the package defaults, so the
  // top-level parameters must stay at those defaults unless this changes too.
  typedef struct packed {
    logic                         write;
    logic [ADDR_W_DEF-1:0]        addr;
    logic [NB_W_DEF-1:0]          nbytes;
    logic [8*MAX_BYTES_DEF-1:0]   wdata;
  } req_t;

  // Oversized requests are shortened to the widest transfer we can buffer.
  function automatic logic [NB_W_DEF-1:0] clamp_nbytes(input logic [NB_W_DEF-1:0] nb);
    return (nb > NB_W_DEF'(MAX_BYTES_DEF)) ? NB_W_DEF'(MAX_BYTES_DEF) : nb;
  endfunction

endpackage

// File: rtl/sail_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the data requester, bit 1 is
// instruction fetch; ptr names the requester that won most recently.
module sail_rr_arb2
  import sail_mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_e    ptr,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ptr == REQ_I) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sail_mem_arbiter.sv
// Shares the byte-wide emulator memory port between the data and fetch
// requesters, serialising each request into one byte per handshake and
// assembling read bytes little-endian.
// Optional: define SAIL_MEM_ARB_PERF_EN to add saturating grant and stall
// counters (perf_d_grants, perf_i_grants, perf_stall_cycles).
module sail_mem_arbiter
  import sail_mem_arb_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic                   d_req_write,
  input  logic [ADDR_W-1:0]      d_req_addr,
  input  logic [NB_W-1:0]        d_req_nbytes,
  input  logic [8*MAX_BYTES-1:0] d_req_wdata,
  output logic                   d_rsp_valid,
  output logic [8*MAX_BYTES-1:0] d_rsp_rdata,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [NB_W-1:0]        i_req_nbytes,
  output logic                   i_rsp_valid,
  output logic [8*MAX_BYTES-1:0] i_rsp_rdata,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata
`ifdef SAIL_MEM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_d_grants,
  output logic [31:0]            perf_i_grants,
  output logic [31:0]            perf_stall_cycles
`endif
);

  state_e                 state_q, state_d;
  req_t                   req_q, req_d;
  req_id_e                owner_q, owner_d;
  req_id_e                last_q, last_d;
  logic [NB_W-1:0]        k_q, k_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [1:0]             grant;
  logic [MAX_BYTES-1:0]   lane_sel;
  logic                   in_xfer;

  sail_rr_arb2 u_rr (
    .valid ({i_req_valid, d_req_valid}),
    .ptr   (last_q),
    .grant (grant)
  );

  // Grants are only offered while idle; they depend on flops and req_valid only.
  assign d_req_ready = (state_q == IDLE) && grant[0];
  assign i_req_ready = (state_q == IDLE) && grant[1];
  assign in_xfer     = (state_q == XFER);

  // One-hot byte-lane select for the byte currently on the memory port.
  generate
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
      assign lane_sel[gi] = (k_q == NB_W'(gi));
    end
  endgenerate

  // Next-state logic: accept in IDLE, step bytes in XFER, retire in RESP.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    last_d  = last_q;
    k_d     = k_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (d_req_ready || i_req_ready) begin
          owner_d      = d_req_ready ? REQ_D : REQ_I;
          req_d.write  = d_req_ready ? d_req_write : 1'b0;
          req_d.addr   = d_req_ready ? d_req_addr : i_req_addr;
          req_d.nbytes = clamp_nbytes(d_req_ready ? d_req_nbytes : i_req_nbytes);
          req_d.wdata  = d_req_ready ? d_req_wdata : '0;
          k_d          = '0;
          buf_d        = '0;
          state_d      = (req_d.nbytes == '0) ? RESP : XFER;
        end
      end
      XFER: begin
        if (mem_ready) begin
          if (!req_q.write) begin
            for (int b = 0; b < MAX_BYTES; b++) begin
              if (lane_sel[b]) buf_d[8*b +: 8] = mem_rdata;
            end
          end
          k_d = k_q + NB_W'(1);
          if ((k_q + NB_W'(1)) == req_q.nbytes) state_d = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= REQ_D;
      last_q  <= REQ_I;
      k_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

  // Memory port is decoded purely from registered state, so it holds during stalls.
  always_comb begin
    mem_valid = in_xfer;
    mem_we    = in_xfer && req_q.write;
    mem_addr  = in_xfer ? (req_q.addr + ADDR_W'(k_q)) : '0;
    mem_wdata = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (in_xfer && lane_sel[b]) mem_wdata = req_q.wdata[8*b +: 8];
    end
  end

  // Response pulse routed to the requester that owns the finished transfer.
  always_comb begin
    d_rsp_valid = (state_q == RESP) && (owner_q == REQ_D);
    i_rsp_valid = (state_q == RESP) && (owner_q == REQ_I);
    d_rsp_rdata = d_rsp_valid ? buf_q : '0;
    i_rsp_rdata = i_rsp_valid ? buf_q : '0;
  end

  // Flag oversized byte counts at acceptance; the datapath clamps them.
  always_ff @(posedge clk) begin
    if (!rst && d_req_ready) assert (d_req_nbytes <= NB_W'(MAX_BYTES));
    if (!rst && i_req_ready) assert (i_req_nbytes <= NB_W'(MAX_BYTES));
  end

`ifdef SAIL_MEM_ARB_PERF_EN
  logic [31:0] perf_d_q, perf_d_d;
  logic [31:0] perf_i_q, perf_i_d;
  logic [31:0] perf_s_q, perf_s_d;

  // Saturating event counters.
  always_comb begin
    perf_d_d = perf_d_q;
    perf_i_d = perf_i_q;
    perf_s_d = perf_s_q;
    if (d_req_ready && (perf_d_q != '1)) perf_d_d = perf_d_q + 32'd1;
    if (i_req_ready && (perf_i_q != '1)) perf_i_d = perf_i_q + 32'd1;
    if (in_xfer && !mem_ready && (perf_s_q != '1)) perf_s_d = perf_s_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_d_q <= '0;
      perf_i_q <= '0;
      perf_s_q <= '0;
    end else begin
      perf_d_q <= perf_d_d;
      perf_i_q <= perf_i_d;
      perf_s_q <= perf_s_d;
    end
  end

  assign perf_d_grants     = perf_d_q;
  assign perf_i_grants     = perf_i_q;
  assign perf_stall_cycles = perf_s_q;
`endif

endmodule
